// File: rtl/uart_pkg.sv
// UART shared constants: register offsets, bit indices, FSM states.
// Used by uart, uart_rx (built only with UART_RX_EN) and the bench.
package uart_pkg;

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_BAUD    = 5'h04;
    localparam logic [4:0] OFF_STATUS  = 5'h08;
    localparam logic [4:0] OFF_RX_DATA = 5'h0C;
    localparam logic [4:0] OFF_TX_DATA = 5'h10;

    localparam int CTRL_EN         = 1;
    localparam int ST_TX_BUSY      = 0;
    localparam int ST_RX_VALID     = 1;
    localparam int ST_RX_OVERRUN   = 2;
    localparam int ST_RX_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // A bit must last at least two clocks so the half-bit point exists.
    function automatic logic [15:0] bit_period(input logic [15:0] baud);
        return (baud < 16'd2) ? 16'd2 : baud;
    endfunction

endpackage

// File: rtl/uart_if.sv
// Register bus between a bus master and the UART.
// One access per ready pulse; data_o is valid only while ready is high.
interface uart_if;

    logic        select;
    logic [3:0]  wstrb;
    logic [4:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;

    modport master (
        output select, wstrb, addr, data_i,
        input  ready, data_o
    );

    modport slave (
        input  select, wstrb, addr, data_i,
        output ready, data_o
    );

endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM and RX status flags.
// Instantiated by uart only when UART_RX_EN is defined.
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] baud,
    input  logic        rx,
    input  logic        rd_data,
    input  logic        clr_overrun,
    input  logic        clr_frame_err,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_overrun,
    output logic        rx_frame_err
);

    logic        sync1, sync2, sync3;
    uart_state_t state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [15:0] period, period_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        done;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            period  <= 16'd2;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            period  <= period_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // Next-state: recheck start at half bit, sample data at bit centres.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 16'd1;
        period_next  = period;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        done         = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt_next = '0;
                    if (sync3 && !sync2) begin
                        state_next  = ST_START;
                        period_next = bit_period(baud);
                    end
                end
                ST_START: begin
                    if (cnt == {1'b0, period[15:1]} - 16'd1) begin
                        cnt_next     = '0;
                        bit_idx_next = '0;
                        state_next   = sync2 ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt == period - 16'd1) begin
                        cnt_next     = '0;
                        shift_next   = {sync2, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_next = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt == period - 16'd1) begin
                        cnt_next   = '0;
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Received byte and flags; a completing byte beats a same-edge read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (done) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (done && rx_valid && !rd_data) begin
                rx_overrun <= 1'b1;
            end else if (clr_overrun) begin
                rx_overrun <= 1'b0;
            end
            if (done && !sync2) begin
                rx_frame_err <= 1'b1;
            end else if (clr_frame_err) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart.sv
// UART top: register bus, transmitter, optional receiver.
// Define UART_RX_EN to build the receiver (uart_rx).
module uart
    import uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_BAUD = 16'd434
) (
    input  logic clk,
    input  logic reset,
    uart_if.slave bus,
    input  logic rx,
    output logic tx
);

    logic        en, en_next;
    logic [15:0] baud;
    logic        access, wr, rd;
    logic [4:0]  reg_addr;
    logic [31:0] rdata;
    logic        tx_busy, tx_start;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_overrun, rx_frame_err;

    uart_state_t tx_state, tx_state_next;
    logic [15:0] tx_cnt, tx_cnt_next;
    logic [15:0] tx_period, tx_period_next;
    logic [2:0]  tx_bit, tx_bit_next;
    logic [7:0]  tx_shift, tx_shift_next;
    logic        tx_next;

    assign access   = bus.select & ~bus.ready;
    assign wr       = access & (bus.wstrb != 4'd0);
    assign rd       = access & (bus.wstrb == 4'd0);
    assign reg_addr = {bus.addr[4:2], 2'b00};
    assign tx_busy  = (tx_state != ST_IDLE);
    assign tx_start = wr && (reg_addr == OFF_TX_DATA)
                      && bus.wstrb[0] && en && !tx_busy;

    // Enable as it will be after this edge, so aborts act immediately.
    always_comb begin
        en_next = en;
        if (wr && reg_addr == OFF_CTRL && bus.wstrb[0]) begin
            en_next = bus.data_i[CTRL_EN];
        end
    end

    // Read data mux; unmapped and write-only offsets read zero.
    always_comb begin
        rdata = '0;
        case (reg_addr)
            OFF_CTRL:    rdata[CTRL_EN] = en;
            OFF_BAUD:    rdata[15:0] = baud;
            OFF_STATUS: begin
                rdata[ST_TX_BUSY]      = tx_busy;
                rdata[ST_RX_VALID]     = rx_valid;
                rdata[ST_RX_OVERRUN]   = rx_overrun;
                rdata[ST_RX_FRAME_ERR] = rx_frame_err;
            end
            OFF_RX_DATA: rdata[7:0] = rx_data;
            default:     rdata = '0;
        endcase
    end

    // Bus handshake, read data and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ready  <= 1'b0;
            bus.data_o <= '0;
            en         <= 1'b0;
            baud       <= DEFAULT_BAUD;
        end else begin
            bus.ready  <= bus.select & ~bus.ready;
            bus.data_o <= rd ? rdata : 32'd0;
            en         <= en_next;
            if (wr && reg_addr == OFF_BAUD) begin
                if (bus.wstrb[0]) baud[7:0]  <= bus.data_i[7:0];
                if (bus.wstrb[1]) baud[15:8] <= bus.data_i[15:8];
            end
        end
    end

    // Transmitter FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_period <= 16'd2;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx        <= 1'b1;
        end else begin
            tx_state  <= tx_state_next;
            tx_cnt    <= tx_cnt_next;
            tx_period <= tx_period_next;
            tx_bit    <= tx_bit_next;
            tx_shift  <= tx_shift_next;
            tx        <= tx_next;
        end
    end

    // Transmitter next-state: start, 8 data bits LSB first, stop.
    always_comb begin
        tx_state_next  = tx_state;
        tx_cnt_next    = tx_cnt + 16'd1;
        tx_period_next = tx_period;
        tx_bit_next    = tx_bit;
        tx_shift_next  = tx_shift;
        tx_next        = tx;
        if (!en_next) begin
            tx_state_next = ST_IDLE;
            tx_cnt_next   = '0;
            tx_next       = 1'b1;
        end else begin
            unique case (tx_state)
                ST_IDLE: begin
                    tx_cnt_next = '0;
                    tx_next     = 1'b1;
                    if (tx_start) begin
                        tx_state_next  = ST_START;
                        tx_period_next = bit_period(baud);
                        tx_shift_next  = bus.data_i[7:0];
                        tx_next        = 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == tx_period - 16'd1) begin
                        tx_cnt_next   = '0;
                        tx_bit_next   = '0;
                        tx_state_next = ST_DATA;
                        tx_next       = tx_shift[0];
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == tx_period - 16'd1) begin
                        tx_cnt_next = '0;
                        if (tx_bit == 3'd7) begin
                            tx_state_next = ST_STOP;
                            tx_next       = 1'b1;
                        end else begin
                            tx_bit_next   = tx_bit + 3'd1;
                            tx_shift_next = {1'b0, tx_shift[7:1]};
                            tx_next       = tx_shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == tx_period - 16'd1) begin
                        tx_cnt_next   = '0;
                        tx_state_next = ST_IDLE;
                    end
                end
                default: tx_state_next = ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_EN
    logic rd_rx_data, clr_overrun, clr_frame_err;
    logic unused_bits;

    assign rd_rx_data    = rd && (reg_addr == OFF_RX_DATA);
    assign clr_overrun   = wr && (reg_addr == OFF_STATUS) && bus.wstrb[0]
                           && bus.data_i[ST_RX_OVERRUN];
    assign clr_frame_err = wr && (reg_addr == OFF_STATUS) && bus.wstrb[0]
                           && bus.data_i[ST_RX_FRAME_ERR];
    assign unused_bits   = ^{bus.data_i[31:16], bus.wstrb[3:2], bus.addr[1:0]};

    uart_rx u_rx (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .baud          (baud),
        .rx            (rx),
        .rd_data       (rd_rx_data),
        .clr_overrun   (clr_overrun),
        .clr_frame_err (clr_frame_err),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_overrun    (rx_overrun),
        .rx_frame_err  (rx_frame_err)
    );
`else
    logic unused_bits;

    assign rx_data      = '0;
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign unused_bits  = ^{bus.data_i[31:16], bus.wstrb[3:2],
                            bus.addr[1:0], rx};
`endif

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: reads push expected data, a monitor
// compares on ready; tx line and receiver are checked via loopback.
module tb_uart;
    import uart_pkg::*;

`ifdef UART_RX_EN
    localparam bit RX_BUILT = 1'b1;
`else
    localparam bit RX_BUILT = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    logic rx;
    logic tx;
    logic rx_manual;
    logic rx_drive;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    uart_if bus ();

    uart #(.DEFAULT_BAUD(16'd434)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .rx    (rx),
        .tx    (tx)
    );

    assign rx = rx_manual ? rx_drive : tx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every read completion pops one expectation.
    always @(negedge clk) begin
        if (bus.ready === 1'b1 && bus.wstrb == 4'd0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%0h expected none",
                         bus.data_o);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.name, bus.data_o, mon_e.exp);
            end
        end
    end

    task automatic access(input logic [4:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        bit got;
        got = 1'b0;
        bus.addr   = a;
        bus.wstrb  = s;
        bus.data_i = d;
        bus.select = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1 at addr 0x%0h", a);
        end
        #1 bus.select = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input string name,
                      input logic [31:0] exp);
        sb.push_back('{name, exp});
        access(a, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] s,
                      input logic [31:0] d);
        access(a, s, d);
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic send(input logic [7:0] b);
        int c;
        wr(OFF_TX_DATA, 4'b0001, {24'd0, b});
        c = ack_cyc;
        wait_until(c + 101);
    endtask

    // Drives one 10-clock-per-bit frame on rx with a chosen stop level.
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx_drive = (k == 9) ? stop : frame_bit(b, k);
            repeat (10) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int lows;
        reset      = 1'b1;
        bus.select = 1'b0;
        bus.wstrb  = 4'd0;
        bus.addr   = 5'd0;
        bus.data_i = 32'd0;
        rx_manual  = 1'b0;
        rx_drive   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_ready", {31'd0, bus.ready}, 32'd0);
        check("reset_data_o", bus.data_o, 32'd0);
        reset = 1'b0;

        rd(OFF_BAUD, "baud_reset", 32'd434);
        rd(OFF_STATUS, "status_reset", 32'd0);
        rd(OFF_CTRL, "ctrl_reset", 32'd0);
        rd(OFF_RX_DATA, "rx_data_reset", 32'd0);
        wr(5'h14, 4'hF, 32'hFFFF_FFFF);
        rd(5'h14, "reserved_read", 32'd0);

        wr(OFF_BAUD, 4'b0011, 32'd10);
        rd(OFF_BAUD, "baud_10", 32'd10);
        @(negedge clk);
        check("ready_one_cycle", {31'd0, bus.ready}, 32'd0);
        wr(OFF_BAUD, 4'b0001, 32'hFFFF_FF0C);
        rd(OFF_BAUD, "baud_lane0_only", 32'd12);
        wr(OFF_BAUD, 4'b0011, 32'd10);
        wr(OFF_CTRL, 4'hF, 32'hFFFF_FFFF);
        rd(OFF_CTRL, "ctrl_en_only", 32'd2);
        rd(OFF_TX_DATA, "tx_data_reads_0", 32'd0);

        wr(OFF_TX_DATA, 4'b0001, 32'h61);
        c0 = ack_cyc;
        check("tx_low_after_write", {31'd0, tx}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            wait_until(c0 + 10 * k + 5);
            check($sformatf("tx_0x61_bit%0d", k), {31'd0, tx},
                  {31'd0, frame_bit(8'h61, k)});
            if (k == 1) begin
                wait_until(c0 + 20);
                wr(OFF_TX_DATA, 4'b0001, 32'h55);
                rd(OFF_STATUS, "status_busy", 32'd1);
            end
        end
        wait_until(c0 + 101);
        rd(OFF_STATUS, "status_after_frame", RX_BUILT ? 32'd2 : 32'd0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("no_second_frame", lows, 32'd0);

        rd(OFF_RX_DATA, "rx_first_byte", RX_BUILT ? 32'h61 : 32'd0);
        rd(OFF_STATUS, "rx_valid_cleared", 32'd0);
        send(8'h65);
        rd(OFF_STATUS, "rx_second_valid", RX_BUILT ? 32'd2 : 32'd0);
        rd(OFF_RX_DATA, "rx_second_byte", RX_BUILT ? 32'h65 : 32'd0);
        rd(OFF_STATUS, "rx_no_overrun", 32'd0);

        send(8'h12);
        send(8'h34);
        rd(OFF_STATUS, "overrun_set", RX_BUILT ? 32'd6 : 32'd0);
        rd(OFF_RX_DATA, "overrun_data", RX_BUILT ? 32'h34 : 32'd0);
        rd(OFF_STATUS, "overrun_sticky", RX_BUILT ? 32'd4 : 32'd0);
        wr(OFF_STATUS, 4'b0001, 32'h4);
        rd(OFF_STATUS, "overrun_cleared", 32'd0);

        rx_manual = 1'b1;
        drive_frame(8'hA5, 1'b0);
        rd(OFF_STATUS, "frame_err_set", RX_BUILT ? 32'hA : 32'd0);
        rd(OFF_RX_DATA, "frame_err_data", RX_BUILT ? 32'hA5 : 32'd0);
        wr(OFF_STATUS, 4'b0001, 32'h8);
        rd(OFF_STATUS, "frame_err_cleared", 32'd0);
        rx_drive = 1'b0;
        repeat (3) @(negedge clk);
        rx_drive = 1'b1;
        repeat (30) @(negedge clk);
        rd(OFF_STATUS, "false_start", 32'd0);
        drive_frame(8'h3C, 1'b1);
        rd(OFF_STATUS, "after_false_start", RX_BUILT ? 32'd2 : 32'd0);
        rd(OFF_RX_DATA, "after_false_data", RX_BUILT ? 32'h3C : 32'd0);
        rx_manual = 1'b0;

        wr(OFF_TX_DATA, 4'b0001, 32'h00);
        c0 = ack_cyc;
        wait_until(c0 + 30);
        check("abort_tx_low_before", {31'd0, tx}, 32'd0);
        wr(OFF_CTRL, 4'b0001, 32'd0);
        check("abort_tx_high", {31'd0, tx}, 32'd1);
        rd(OFF_STATUS, "abort_status", 32'd0);
        wr(OFF_TX_DATA, 4'b0001, 32'hAA);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("tx_disabled_discard", lows, 32'd0);
        rx_manual = 1'b1;
        drive_frame(8'h5A, 1'b1);
        rx_manual = 1'b0;
        rd(OFF_STATUS, "rx_disabled", 32'd0);

        wr(OFF_CTRL, 4'b0001, 32'd2);
        wr(OFF_TX_DATA, 4'b0001, 32'h00);
        c0 = ack_cyc;
        wait_until(c0 + 30);
        check("reset_mid_tx_low", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_tx_high", {31'd0, tx}, 32'd1);
        check("reset_mid_ready", {31'd0, bus.ready}, 32'd0);
        reset = 1'b0;
        rd(OFF_BAUD, "reset_mid_baud", 32'd434);
        rd(OFF_CTRL, "reset_mid_ctrl", 32'd0);
        rd(OFF_STATUS, "reset_mid_status", 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameters: DEFAULT_BAUD, 16'd434, reset value of BAUD register (clocks per bit).
REQ-002 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 Port reset, input, 1; reset is synchronous and active-high.
REQ-004 Port select, input, 1, bus access request (address decode done outside).
REQ-005 Port wstrb, input, 4, byte write strobes; nonzero = write, zero = read.
REQ-006 Port addr, input, 5, register byte offset.
REQ-007 Port data_i, input, 32, write data.
REQ-008 Port ready, output, 1, access-complete pulse.
REQ-009 Port data_o, output, 32, read data, valid while ready=1, else 0.
REQ-010 Port rx, input, 1, serial in (asynchronous, idle high).
REQ-011 Port tx, output, 1, serial out (idle high).

Function
REQ-012 Register map SHALL be: 0x00 CTRL (bit1 EN, others read 0); 0x04 BAUD[15:0]; 0x08 STATUS (bit0 TX_BUSY, bit1 RX_VALID, bit2 RX_OVERRUN, bit3 RX_FRAME_ERR); 0x0C RX_DATA[7:0]; 0x10 TX_DATA[7:0] (write-only, reads 0); 0x14-0x1C reserved, read 0, writes ignored.
REQ-013 ready SHALL be registered: ready <= select & ~ready; each access completes in exactly one cycle after select rises; select held high yields ready every other cycle, one access per ready pulse.
REQ-014 Register writes and read side effects SHALL take effect on the edge where ready rises; wstrb lanes gate byte updates; unused bits ignored.
REQ-015 Bit period SHALL be max(BAUD,2) clk cycles; BAUD change takes effect at next frame start.
REQ-016 TX frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10 bit periods total.
REQ-017 Write to TX_DATA with EN=1 and TX_BUSY=0 SHALL start a frame; tx drops low on the cycle after the write; TX_BUSY=1 from that cycle until stop bit completes.
REQ-018 Write to TX_DATA while TX_BUSY=1 or EN=0 SHALL be discarded.
REQ-019 TX state machine: IDLE -> START -> DATA(8) -> STOP -> IDLE.
REQ-020 RX: rx passed through 2-flop synchronizer; falling edge in IDLE starts frame; start bit re-checked at BAUD/2, false start returns to IDLE; data bits sampled at bit centres.
REQ-021 On stop bit sample: byte loaded to RX_DATA, RX_VALID=1; stop=0 sets RX_FRAME_ERR (byte still loaded).
REQ-022 New byte while RX_VALID=1 SHALL set RX_OVERRUN and overwrite RX_DATA.
REQ-023 Reading RX_DATA SHALL clear RX_VALID; writing 1 to STATUS bit2/bit3 SHALL clear that flag; byte completing on same edge as read wins (RX_VALID stays 1).
REQ-024 Clearing EN mid-frame SHALL abort both TX and RX: tx=1, FSMs to IDLE, TX_BUSY=0; RX receives nothing while EN=0.

Reset
REQ-025 On reset: ready=0, data_o=0, tx=1, CTRL=0, BAUD=DEFAULT_BAUD, RX_DATA=0, all STATUS bits 0, FSMs IDLE, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL abort immediately with above values on next edge.

Configuration
REQ-027 Macro UART_RX_EN: defined -> receiver built per REQ-020..023; undefined -> no receiver logic, rx ignored, RX_DATA and STATUS bits1-3 read 0.

Structure
REQ-028 Package uart_pkg SHALL hold register offset constants, CTRL/STATUS bit indices and the FSM state typedef.
REQ-029 Receiver SHALL be sub-module uart_rx (instantiated only under UART_RX_EN); transmitter and bus logic in uart.

Verification
REQ-030 Reset then read 0x04 -> data_o=434, read 0x08 -> 0.
REQ-031 Write 0x04=10, read 0x04 -> 10; ready high exactly one cycle per access.
REQ-032 BAUD=10, CTRL=0x2, write TX_DATA=0x61 -> tx low 10 cycles, bits 1,0,0,0,0,1,1,0 each 10 cycles, stop high; TX_BUSY clear after 100 cycles.
REQ-033 Loopback tx->rx, send 0x61 then 0x65 -> RX_VALID=1, RX_DATA=0x61, after read RX_VALID=0; second byte 0x65 received, no overrun.
REQ-034 Second TX_DATA write at cycle 20 of frame -> discarded, only one frame on tx.
REQ-035 Send two bytes without reading RX_DATA -> RX_OVERRUN=1, RX_DATA=second byte; CTRL=0 mid-frame -> tx=1 next cycle.
